uart_dbg_bridge: RTL and testbench
==================================

// Module: uart_dbg_bridge
// PURPOSE
//  Host-side debug bridge feeding the SoC external-master port. Deserialises 8N1 UART command frames
//  from a host, drives the ext_tran_* request/ready/clear handshake, and returns status/read data over UART.
//  Also owns bus-master select, CPU reset and CPU halt, so the host can load firmware before releasing the CPU.
// PARAMETERS
//  CLKS_PER_BIT    434    clk_i cycles per UART bit (50 MHz / 115200); must be >= 4
//  TIMEOUT_CYCLES  65535  max cycles from start pulse to ext_tran_ready_i before an error is reported
// PORTS
//  clk_i             in   1   single clock, all logic rising-edge
//  rst_i             in   1   synchronous active-high reset
//  uart_rx_i         in   1   host serial in, asynchronous, idle high
//  uart_tx_o         out  1   host serial out, idle high
//  ext_tran_addr_o   out  32  transaction address
//  ext_tran_data_o   out  32  write data
//  ext_tran_size_o   out  2   0=byte 1=half 2=word (3 reserved)
//  ext_tran_write_o  out  1   1=write 0=read
//  ext_tran_start_o  out  1   one-cycle request pulse
//  ext_tran_clear_o  out  1   one-cycle ready-acknowledge pulse
//  ext_tran_data_i   in   32  read data, valid while ext_tran_ready_i=1
//  ext_tran_ready_i  in   1   transaction complete, level, held until clear
//  bus_master_o      out  1   1=external port owns bus, 0=CPU
//  cpu_rst_o         out  1   CPU reset request
//  cpu_halt_o        out  1   CPU halt request
// BEHAVIOUR
//  Reset: uart_tx_o=1, start/clear=0, addr/data/size/write=0, bus_master_o=1, cpu_rst_o=1, cpu_halt_o=0.
//   Reset mid-frame or mid-transaction aborts everything; no clear pulse is issued and no response is sent.
//  RX: 2-flop sync; falling edge in idle starts frame; start bit rechecked at CLKS_PER_BIT/2 (high -> glitch,
//   back to idle); data LSB first, sampled mid-bit; stop bit 0 -> framing error, byte dropped, parser -> P_IDLE.
//  TX: 8N1, LSB first, one byte at a time; multi-byte responses sent back-to-back without idle bits.
//  Frame = cmd byte, then operands LSB first. cmd[7:4] opcode, cmd[3:0] argument:
//   0x1 READ  : +4 addr bytes; cmd[1:0]=size        -> 'K'(0x4B) + 4 data bytes LSB first
//   0x2 WRITE : +4 addr +4 data bytes; cmd[1:0]=size -> 'K'
//   0x3 CTRL  : cmd[0]->bus_master_o, cmd[1]->cpu_rst_o, cmd[2]->cpu_halt_o, applied the cycle the byte
//               is accepted -> 'K'
//   0x4 PING  : -> 0xA5
//   anything else, size==3, or READ/WRITE with bus_master_o=0 -> 'E'(0x45); no transaction is started.
//   Error checks for size, opcode and bus master are made once the frame's last byte has been received.
//  FSM: P_IDLE -> P_ADDR(4) -> [P_WDATA(4)] -> P_START -> P_WAIT -> P_CLEAR -> P_RESP -> P_IDLE.
//   P_START: drive addr/data/size/write stable, start=1 for exactly 1 cycle; outputs stay stable until P_RESP.
//   P_WAIT: ready_i=1 -> latch ext_tran_data_i that cycle -> P_CLEAR (clear=1 for 1 cycle).
//    Start-to-ready latency is >= 1 cycle. ready_i already high in the P_START cycle is ignored.
//   Timeout: counter reaches TIMEOUT_CYCLES in P_WAIT -> clear pulse, response 'E'.
//  Bytes received outside P_IDLE/P_ADDR/P_WDATA (P_START..P_RESP) are dropped; the host waits for the response.
//  Byte counter wraps only via FSM; the 32-bit operand assembles as shift-in from the MSB end.
// STRUCTURE
//  uart_dbg_defs.vh: opcode constants, response codes (K/E/A5), P_* state encodings, size encodings.
//  Sub-module uart_dbg_rx: synchroniser + 8N1 receiver, outputs rx_byte[7:0], rx_valid (1-cycle pulse),
//   rx_frame_err. TX serialiser, parser FSM and timeout counter are inline.
// TESTING (CLKS_PER_BIT=4, TIMEOUT_CYCLES=16, ext port modelled by a BFM)
//  Reset -> tx=1, bus_master=1, cpu_rst=1, halt=0; PING 0x40 -> tx byte 0xA5.
//  WRITE 0x22, addr 00 10 00 00, data EF BE AD DE -> start pulse with addr=0x1000, data=0xDEADBEEF,
//   size=2, write=1; ready after 3 cycles -> single clear pulse, reply 'K'.
//  READ 0x12 addr 0x1000, BFM returns 0xCAFEF00D -> 4B 0D F0 FE CA.
//  READ with ready never asserted -> clear pulse after 16 cycles in P_WAIT, reply 'E';
//   size=3 or opcode 0x9 -> 'E', no start pulse.
//  CTRL 0x30 -> bus_master=0, cpu_rst=0, halt=0, 'K'; following READ -> 'E', no start pulse.
//  Framing error (stop=0) mid-address -> parser back to P_IDLE, next PING answered 0xA5;
//   rst_i in P_WAIT -> reset values next cycle, tx line high.

Source files
------------

// File: rtl/uart_dbg_pkg.sv
// Shared definitions for the UART debug bridge: opcodes, response codes,
// parser/receiver state encodings and the response frame builder.
package uart_dbg_pkg;

  typedef enum logic [2:0] {
    P_IDLE  = 3'd0,
    P_ADDR  = 3'd1,
    P_WDATA = 3'd2,
    P_START = 3'd3,
    P_WAIT  = 3'd4,
    P_CLEAR = 3'd5,
    P_RESP  = 3'd6
  } parser_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_t;

  localparam logic [3:0] OP_READ  = 4'h1;
  localparam logic [3:0] OP_WRITE = 4'h2;
  localparam logic [3:0] OP_CTRL  = 4'h3;
  localparam logic [3:0] OP_PING  = 4'h4;

  localparam logic [7:0] RESP_K    = 8'h4B;
  localparam logic [7:0] RESP_E    = 8'h45;
  localparam logic [7:0] RESP_PING = 8'hA5;

  localparam logic [1:0] SIZE_RSVD = 2'd3;

  localparam logic [5:0] RESP_BITS_SHORT = 6'd10;
  localparam logic [5:0] RESP_BITS_LONG  = 6'd50;

  // Five 8N1 frames packed LSB-first: code byte, then data LSB first.
  // Short responses just shift out the first 10 bits.
  function automatic logic [49:0] resp_frames(input logic [7:0] code, input logic [31:0] data);
    return {1'b1, data[31:24], 1'b0,
            1'b1, data[23:16], 1'b0,
            1'b1, data[15:8],  1'b0,
            1'b1, data[7:0],   1'b0,
            1'b1, code,        1'b0};
  endfunction

endpackage

// File: rtl/uart_dbg_rx.sv
// 8N1 UART receiver with a two-flop synchroniser. Emits a one-cycle rx_valid
// per good byte, or a one-cycle rx_frame_err when the stop bit reads low.
module uart_dbg_rx
  import uart_dbg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_async,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     state;
  logic          sync1, sync2, prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1        <= 1'b1;
      sync2        <= 1'b1;
      prev         <= 1'b1;
      state        <= R_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      rx_byte      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      sync1        <= rx_async;
      sync2        <= sync1;
      prev         <= sync2;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      case (state)
        // A true high-to-low edge is required, so a held-low break line
        // after a framing error does not retrigger.
        R_IDLE: begin
          cnt <= '0;
          if (prev && !sync2) state <= R_START;
        end
        R_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= sync2 ? R_IDLE : R_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        R_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {sync2, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= R_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        R_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= R_IDLE;
            if (sync2) begin
              rx_byte  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              rx_frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_dbg_bridge.sv
// Host UART debug bridge: parses command frames, runs one external-master
// transaction at a time, owns bus-master/CPU reset/CPU halt, replies over UART.
module uart_dbg_bridge
  import uart_dbg_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 434,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic [31:0] ext_tran_addr_o,
  output logic [31:0] ext_tran_data_o,
  output logic [1:0]  ext_tran_size_o,
  output logic        ext_tran_write_o,
  output logic        ext_tran_start_o,
  output logic        ext_tran_clear_o,
  input  logic [31:0] ext_tran_data_i,
  input  logic        ext_tran_ready_i,
  output logic        bus_master_o,
  output logic        cpu_rst_o,
  output logic        cpu_halt_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_frame_err;

  uart_dbg_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk_i),
    .rst         (rst_i),
    .rx_async    (uart_rx_i),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err)
  );

  parser_state_t state;
  logic [3:0]    op_q;
  logic [1:0]    size_q;
  logic [1:0]    byte_cnt;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [TW-1:0] tmo_cnt;
  logic [49:0]   tx_shift;
  logic [5:0]    tx_bits_left;
  logic [CW-1:0] tx_cnt;

  logic [31:0] addr_next;
  logic [31:0] wdata_next;
  logic        launch_ok;

  // Operands arrive LSB first, so each byte enters at the MSB end.
  assign addr_next  = {rx_byte, addr_q[31:8]};
  assign wdata_next = {rx_byte, wdata_q[31:8]};
  assign launch_ok  = bus_master_o && (size_q != SIZE_RSVD);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= P_IDLE;
      op_q             <= '0;
      size_q           <= '0;
      byte_cnt         <= '0;
      addr_q           <= '0;
      wdata_q          <= '0;
      tmo_cnt          <= '0;
      tx_shift         <= '0;
      tx_bits_left     <= '0;
      tx_cnt           <= '0;
      uart_tx_o        <= 1'b1;
      ext_tran_addr_o  <= '0;
      ext_tran_data_o  <= '0;
      ext_tran_size_o  <= '0;
      ext_tran_write_o <= 1'b0;
      ext_tran_start_o <= 1'b0;
      ext_tran_clear_o <= 1'b0;
      bus_master_o     <= 1'b1;
      cpu_rst_o        <= 1'b1;
      cpu_halt_o       <= 1'b0;
    end else begin
      ext_tran_start_o <= 1'b0;
      ext_tran_clear_o <= 1'b0;
      if (state != P_RESP) tx_cnt <= '0;
      case (state)
        P_IDLE: begin
          if (rx_valid) begin
            op_q     <= rx_byte[7:4];
            size_q   <= rx_byte[1:0];
            byte_cnt <= '0;
            case (rx_byte[7:4])
              OP_READ, OP_WRITE: state <= P_ADDR;
              OP_CTRL: begin
                bus_master_o <= rx_byte[0];
                cpu_rst_o    <= rx_byte[1];
                cpu_halt_o   <= rx_byte[2];
                tx_shift     <= resp_frames(RESP_K, '0);
                tx_bits_left <= RESP_BITS_SHORT;
                state        <= P_RESP;
              end
              OP_PING: begin
                tx_shift     <= resp_frames(RESP_PING, '0);
                tx_bits_left <= RESP_BITS_SHORT;
                state        <= P_RESP;
              end
              default: begin
                tx_shift     <= resp_frames(RESP_E, '0);
                tx_bits_left <= RESP_BITS_SHORT;
                state        <= P_RESP;
              end
            endcase
          end
        end
        P_ADDR: begin
          if (rx_frame_err) begin
            state <= P_IDLE;
          end else if (rx_valid) begin
            addr_q   <= addr_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (op_q == OP_WRITE) begin
                state <= P_WDATA;
              end else if (launch_ok) begin
                ext_tran_addr_o  <= addr_next;
                ext_tran_data_o  <= '0;
                ext_tran_size_o  <= size_q;
                ext_tran_write_o <= 1'b0;
                ext_tran_start_o <= 1'b1;
                state            <= P_START;
              end else begin
                tx_shift     <= resp_frames(RESP_E, '0);
                tx_bits_left <= RESP_BITS_SHORT;
                state        <= P_RESP;
              end
            end
          end
        end
        P_WDATA: begin
          if (rx_frame_err) begin
            state <= P_IDLE;
          end else if (rx_valid) begin
            wdata_q  <= wdata_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (launch_ok) begin
                ext_tran_addr_o  <= addr_q;
                ext_tran_data_o  <= wdata_next;
                ext_tran_size_o  <= size_q;
                ext_tran_write_o <= 1'b1;
                ext_tran_start_o <= 1'b1;
                state            <= P_START;
              end else begin
                tx_shift     <= resp_frames(RESP_E, '0);
                tx_bits_left <= RESP_BITS_SHORT;
                state        <= P_RESP;
              end
            end
          end
        end
        // ready_i is deliberately not looked at while start is high.
        P_START: begin
          tmo_cnt <= '0;
          state   <= P_WAIT;
        end
        P_WAIT: begin
          if (ext_tran_ready_i) begin
            ext_tran_clear_o <= 1'b1;
            tx_shift         <= resp_frames(RESP_K, ext_tran_data_i);
            tx_bits_left     <= ext_tran_write_o ? RESP_BITS_SHORT : RESP_BITS_LONG;
            state            <= P_CLEAR;
          end else if (tmo_cnt == TMO_LAST) begin
            ext_tran_clear_o <= 1'b1;
            tx_shift         <= resp_frames(RESP_E, '0);
            tx_bits_left     <= RESP_BITS_SHORT;
            state            <= P_CLEAR;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        P_CLEAR: state <= P_RESP;
        // All response frames form one bit stream, so bytes go out back to back.
        P_RESP: begin
          if (tx_cnt == '0) begin
            uart_tx_o    <= tx_shift[0];
            tx_shift     <= {1'b1, tx_shift[49:1]};
            tx_bits_left <= tx_bits_left - 6'd1;
          end
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bits_left == 6'd0) state <= P_IDLE;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        default: state <= P_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_dbg_bridge.sv
// Bench for uart_dbg_bridge: UART host driver, TX decoder, external-port BFM
// and a byte scoreboard of expected responses.
module tb_uart_dbg_bridge;

  localparam int CPB = 4;
  localparam int TMO = 16;
  localparam logic [7:0] K_BYTE = 8'h4B;
  localparam logic [7:0] E_BYTE = 8'h45;
  localparam logic [7:0] P_BYTE = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic [31:0] ext_addr, ext_wdata;
  logic [31:0] ext_rdata = '0;
  logic [1:0]  ext_size;
  logic        ext_write, ext_start, ext_clear;
  logic        ext_ready = 1'b0;
  logic        bus_master, cpu_rst, cpu_halt;

  int total = 0;
  int passed = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_t[$];
  int         cyc = 0;
  int         tx_stop_err = 0;

  int          start_cnt = 0, clear_cnt = 0, start_cyc = 0, clear_cyc = 0;
  logic [31:0] cap_addr, cap_data;
  logic [1:0]  cap_size;
  logic        cap_write;
  int          bfm_delay = 3;
  bit          bfm_never = 1'b0;
  logic [31:0] bfm_rdata = '0;
  bit          pending = 1'b0;
  int          wait_ctr = 0;

  uart_dbg_bridge #(
    .CLKS_PER_BIT  (CPB),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .uart_rx_i       (uart_rx),
    .uart_tx_o       (uart_tx),
    .ext_tran_addr_o (ext_addr),
    .ext_tran_data_o (ext_wdata),
    .ext_tran_size_o (ext_size),
    .ext_tran_write_o(ext_write),
    .ext_tran_start_o(ext_start),
    .ext_tran_clear_o(ext_clear),
    .ext_tran_data_i (ext_rdata),
    .ext_tran_ready_i(ext_ready),
    .bus_master_o    (bus_master),
    .cpu_rst_o       (cpu_rst),
    .cpu_halt_o      (cpu_halt)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // External port BFM: captures each request, answers after bfm_delay cycles
  always @(negedge clk) begin
    if (rst) begin
      pending   = 1'b0;
      ext_ready = 1'b0;
      wait_ctr  = 0;
    end else begin
      if (ext_start === 1'b1) begin
        start_cnt++;
        start_cyc = cyc;
        cap_addr  = ext_addr;
        cap_data  = ext_wdata;
        cap_size  = ext_size;
        cap_write = ext_write;
        pending   = 1'b1;
        wait_ctr  = 0;
      end else if (pending && !ext_ready && !bfm_never) begin
        wait_ctr++;
        if (wait_ctr >= bfm_delay) begin
          ext_ready = 1'b1;
          ext_rdata = bfm_rdata;
        end
      end
      if (ext_clear === 1'b1) begin
        clear_cnt++;
        clear_cyc = cyc;
        ext_ready = 1'b0;
        ext_rdata = '0;
        pending   = 1'b0;
      end
    end
  end

  // UART TX decoder: timestamps each start bit, samples mid-bit
  always begin : tx_mon
    logic [7:0] b;
    int t;
    @(negedge clk);
    if (rst === 1'b0 && uart_tx === 1'b0) begin
      t = cyc;
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = uart_tx;
      end
      repeat (CPB) @(negedge clk);
      if (uart_tx !== 1'b1) tx_stop_err++;
      got_q.push_back(b);
      got_t.push_back(t);
    end
  end

  // Driver tasks
  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = ~bad_stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_tx(input int n, output bit ok);
    int budget;
    budget = 3000;
    while (got_q.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    ok = (got_q.size() >= n);
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (uart_tx !== 1'b1) $display("FAIL reset_tx got %b need 1", uart_tx); else passed++;
    total++; if (bus_master !== 1'b1) $display("FAIL reset_bus_master got %b need 1", bus_master); else passed++;
    total++; if (cpu_rst !== 1'b1) $display("FAIL reset_cpu_rst got %b need 1", cpu_rst); else passed++;
    total++; if (cpu_halt !== 1'b0) $display("FAIL reset_cpu_halt got %b need 0", cpu_halt); else passed++;
    total++;
    if ({ext_start, ext_clear, ext_write, ext_size} !== 5'b0 || ext_addr !== 32'h0 || ext_wdata !== 32'h0)
      $display("FAIL reset_ext got start=%b clear=%b write=%b size=%0d addr=%h data=%h need all zero",
               ext_start, ext_clear, ext_write, ext_size, ext_addr, ext_wdata);
    else passed++;
  endtask

  task automatic test_ping();
    bit ok;
    logic [7:0] e, g;
    int t;
    exp_q.push_back(P_BYTE);
    send_byte(8'h40, 1'b0);
    wait_tx(exp_q.size(), ok);
    total++; if (!ok) $display("FAIL ping_count got %0d bytes need %0d", got_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); t = got_t.pop_front();
      total++; if (g !== e) $display("FAIL ping_byte got %h need %h at %0d", g, e, t); else passed++;
    end
  endtask

  task automatic test_write();
    bit ok;
    logic [7:0] e, g;
    int t, s0, c0;
    logic [7:0] frame[$];
    frame = '{8'h22, 8'h00, 8'h10, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    s0 = start_cnt; c0 = clear_cnt; bfm_delay = 3; bfm_never = 1'b0;
    exp_q.push_back(K_BYTE);
    foreach (frame[i]) send_byte(frame[i], 1'b0);
    wait_tx(exp_q.size(), ok);
    total++; if (!ok) $display("FAIL write_count got %0d bytes need %0d", got_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); t = got_t.pop_front();
      total++; if (g !== e) $display("FAIL write_resp got %h need %h at %0d", g, e, t); else passed++;
    end
    total++; if (start_cnt - s0 != 1) $display("FAIL write_start_pulses got %0d need 1", start_cnt - s0); else passed++;
    total++; if (clear_cnt - c0 != 1) $display("FAIL write_clear_pulses got %0d need 1", clear_cnt - c0); else passed++;
    total++; if (cap_addr !== 32'h0000_1000) $display("FAIL write_addr got %h need 00001000", cap_addr); else passed++;
    total++; if (cap_data !== 32'hDEAD_BEEF) $display("FAIL write_data got %h need deadbeef", cap_data); else passed++;
    total++;
    if (cap_size !== 2'd2 || cap_write !== 1'b1)
      $display("FAIL write_attr got size=%0d write=%b need size=2 write=1", cap_size, cap_write);
    else passed++;
  endtask

  task automatic test_read_back_to_back();
    bit ok;
    logic [7:0] e, g;
    int t, tp, s0;
    logic [7:0] frame[$];
    frame = '{8'h12, 8'h00, 8'h10, 8'h00, 8'h00};
    s0 = start_cnt; bfm_delay = 2; bfm_never = 1'b0; bfm_rdata = 32'hCAFE_F00D;
    exp_q.push_back(K_BYTE); exp_q.push_back(8'h0D); exp_q.push_back(8'hF0);
    exp_q.push_back(8'hFE); exp_q.push_back(8'hCA);
    foreach (frame[i]) send_byte(frame[i], 1'b0);
    wait_tx(exp_q.size(), ok);
    total++; if (!ok) $display("FAIL read_count got %0d bytes need %0d", got_q.size(), exp_q.size()); else passed++;
    tp = -1;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); t = got_t.pop_front();
      total++; if (g !== e) $display("FAIL read_resp got %h need %h at %0d", g, e, t); else passed++;
      if (tp >= 0) begin
        total++;
        if (t - tp != 10 * CPB) $display("FAIL read_byte_gap got %0d cycles need %0d", t - tp, 10 * CPB);
        else passed++;
      end
      tp = t;
    end
    total++; if (start_cnt - s0 != 1) $display("FAIL read_start_pulses got %0d need 1", start_cnt - s0); else passed++;
    total++;
    if (cap_addr !== 32'h0000_1000 || cap_write !== 1'b0 || cap_size !== 2'd2)
      $display("FAIL read_req got addr=%h write=%b size=%0d need 00001000/0/2", cap_addr, cap_write, cap_size);
    else passed++;
  endtask

  task automatic test_timeout();
    bit ok;
    logic [7:0] e, g;
    int t, s0, c0;
    logic [7:0] frame[$];
    frame = '{8'h12, 8'h00, 8'h20, 8'h00, 8'h00};
    s0 = start_cnt; c0 = clear_cnt; bfm_never = 1'b1;
    exp_q.push_back(E_BYTE);
    foreach (frame[i]) send_byte(frame[i], 1'b0);
    wait_tx(exp_q.size(), ok);
    total++; if (!ok) $display("FAIL timeout_count got %0d bytes need %0d", got_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); t = got_t.pop_front();
      total++; if (g !== e) $display("FAIL timeout_resp got %h need %h at %0d", g, e, t); else passed++;
    end
    total++;
    if (start_cnt - s0 != 1 || clear_cnt - c0 != 1)
      $display("FAIL timeout_pulses got start=%0d clear=%0d need 1/1", start_cnt - s0, clear_cnt - c0);
    else passed++;
    // start cycle, then TMO cycles in P_WAIT, then the clear cycle
    total++;
    if (clear_cyc - start_cyc != TMO + 1)
      $display("FAIL timeout_latency got %0d cycles need %0d", clear_cyc - start_cyc, TMO + 1);
    else passed++;
    bfm_never = 1'b0;
  endtask

  task automatic test_errors();
    bit ok;
    logic [7:0] e, g;
    int t, s0, c0;
    logic [7:0] frame[$];
    frame = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h00,
              8'h90,
              8'h23, 8'h04, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    s0 = start_cnt; c0 = clear_cnt;
    exp_q.push_back(E_BYTE); exp_q.push_back(E_BYTE); exp_q.push_back(E_BYTE);
    for (int i = 0; i < 5; i++) send_byte(frame[i], 1'b0);
    wait_tx(1, ok);
    send_byte(frame[5], 1'b0);
    wait_tx(2, ok);
    for (int i = 6; i < 15; i++) send_byte(frame[i], 1'b0);
    wait_tx(exp_q.size(), ok);
    total++; if (!ok) $display("FAIL errors_count got %0d bytes need %0d", got_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); t = got_t.pop_front();
      total++; if (g !== e) $display("FAIL errors_resp got %h need %h at %0d", g, e, t); else passed++;
    end
    total++;
    if (start_cnt != s0 || clear_cnt != c0)
      $display("FAIL errors_no_tran got start=%0d clear=%0d need 0/0", start_cnt - s0, clear_cnt - c0);
    else passed++;
  endtask

  task automatic test_ctrl();
    bit ok;
    logic [7:0] e, g;
    int t, s0;
    logic [7:0] frame[$];
    frame = '{8'h12, 8'h00, 8'h10, 8'h00, 8'h00};
    s0 = start_cnt;
    exp_q.push_back(K_BYTE);
    send_byte(8'h30, 1'b0);
    wait_tx(1, ok);
    total++;
    if (bus_master !== 1'b0 || cpu_rst !== 1'b0 || cpu_halt !== 1'b0)
      $display("FAIL ctrl_30 got bm=%b rst=%b halt=%b need 0/0/0", bus_master, cpu_rst, cpu_halt);
    else passed++;
    exp_q.push_back(E_BYTE);
    foreach (frame[i]) send_byte(frame[i], 1'b0);
    wait_tx(2, ok);
    exp_q.push_back(K_BYTE);
    send_byte(8'h37, 1'b0);
    wait_tx(exp_q.size(), ok);
    total++;
    if (bus_master !== 1'b1 || cpu_rst !== 1'b1 || cpu_halt !== 1'b1)
      $display("FAIL ctrl_37 got bm=%b rst=%b halt=%b need 1/1/1", bus_master, cpu_rst, cpu_halt);
    else passed++;
    total++; if (!ok) $display("FAIL ctrl_count got %0d bytes need %0d", got_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); t = got_t.pop_front();
      total++; if (g !== e) $display("FAIL ctrl_resp got %h need %h at %0d", g, e, t); else passed++;
    end
    total++; if (start_cnt != s0) $display("FAIL ctrl_no_start got %0d pulses need 0", start_cnt - s0); else passed++;
  endtask

  task automatic test_frame_err();
    bit ok;
    logic [7:0] e, g;
    int t;
    send_byte(8'h12, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b1);
    repeat (4 * CPB) @(negedge clk);
    exp_q.push_back(P_BYTE);
    send_byte(8'h40, 1'b0);
    wait_tx(exp_q.size(), ok);
    total++; if (!ok) $display("FAIL framing_count got %0d bytes need %0d", got_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); t = got_t.pop_front();
      total++; if (g !== e) $display("FAIL framing_resp got %h need %h at %0d", g, e, t); else passed++;
    end
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    logic [7:0] e, g;
    int t, s0, c0, budget;
    logic [7:0] frame[$];
    frame = '{8'h12, 8'h00, 8'h30, 8'h00, 8'h00};
    s0 = start_cnt; bfm_never = 1'b1;
    foreach (frame[i]) send_byte(frame[i], 1'b0);
    budget = 200;
    while (start_cnt == s0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    total++; if (start_cnt == s0) $display("FAIL rstwait_start got 0 pulses need 1"); else passed++;
    repeat (5) @(negedge clk);
    c0 = clear_cnt;
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (uart_tx !== 1'b1 || bus_master !== 1'b1 || cpu_rst !== 1'b1 || cpu_halt !== 1'b0 ||
        ext_start !== 1'b0 || ext_clear !== 1'b0 || ext_addr !== 32'h0)
      $display("FAIL rstwait_values got tx=%b bm=%b rst=%b halt=%b start=%b clear=%b addr=%h need 1/1/1/0/0/0/0",
               uart_tx, bus_master, cpu_rst, cpu_halt, ext_start, ext_clear, ext_addr);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    bfm_never = 1'b0;
    repeat (30 * CPB) @(negedge clk);
    total++;
    if (clear_cnt != c0 || got_q.size() != 0)
      $display("FAIL rstwait_silent got clear=%0d bytes=%0d need 0/0", clear_cnt - c0, got_q.size());
    else passed++;
    exp_q.push_back(P_BYTE);
    send_byte(8'h40, 1'b0);
    wait_tx(exp_q.size(), ok);
    total++; if (!ok) $display("FAIL rstwait_count got %0d bytes need %0d", got_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); t = got_t.pop_front();
      total++; if (g !== e) $display("FAIL rstwait_resp got %h need %h at %0d", g, e, t); else passed++;
    end
  endtask

  task automatic test_final();
    total++; if (tx_stop_err != 0) $display("FAIL tx_stop_bits got %0d bad need 0", tx_stop_err); else passed++;
    total++; if (got_q.size() != 0) $display("FAIL tx_extra_bytes got %0d need 0", got_q.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_ping();
    test_write();
    test_read_back_to_back();
    test_timeout();
    test_errors();
    test_ctrl();
    test_frame_err();
    test_reset_in_wait();
    test_final();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
